// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial-flash target: decodes READ / FAST READ / JEDEC ID / READ STATUS
// and streams bytes from a synchronous memory port out on MISO, oversampling the SPI pins on clk.
module spi_flash_responder #(
    parameter int          ADDR_WIDTH = 16,
    parameter logic [23:0] JEDEC_ID   = 24'hEF4016
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_SPI_CLK,
    input  logic                  i_SPI_MOSI,
    input  logic                  i_SPI_CS,
    output logic                  o_SPI_MISO,
    output logic [ADDR_WIDTH-1:0] o_MEM_ADDR,
    output logic                  o_MEM_RD,
    input  logic [7:0]            i_MEM_DATA,
    output logic                  o_ACTIVE
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;
    typedef enum logic [1:0] {SRC_MEM, SRC_ID, SRC_STATUS} src_t;

    state_t                state;
    src_t                  src;
    logic                  sclk_s1, sclk_s2, sclk_s3;
    logic                  mosi_s1, mosi_s2;
    logic                  cs_s1, cs_s2;
    logic                  sclk_rise, sclk_fall;
    logic [4:0]            bit_cnt;
    logic [6:0]            shift_in;
    logic [ADDR_WIDTH-1:0] addr_sr;
    logic [7:0]            sreg;
    logic [7:0]            next_byte;
    logic                  byte_ready;
    logic                  first_load;
    logic                  fast;
    logic                  rd_d;
    logic                  armed;
    logic [1:0]            id_idx;

    function automatic logic [7:0] id_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    id_byte = JEDEC_ID[23:16];
            2'd1:    id_byte = JEDEC_ID[15:8];
            2'd2:    id_byte = JEDEC_ID[7:0];
            default: id_byte = 8'h00;
        endcase
    endfunction

    // Two-flop synchronizers for the SPI pins, plus one extra SCLK stage for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            {sclk_s1, sclk_s2, sclk_s3} <= 3'b000;
            {mosi_s1, mosi_s2}          <= 2'b00;
            {cs_s1, cs_s2}              <= 2'b00;
        end else begin
            sclk_s1 <= i_SPI_CLK;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            mosi_s1 <= i_SPI_MOSI;
            mosi_s2 <= mosi_s1;
            cs_s1   <= i_SPI_CS;
            cs_s2   <= cs_s1;
        end
    end

    assign sclk_rise = sclk_s2 & ~sclk_s3;
    assign sclk_fall = ~sclk_s2 & sclk_s3;

    // Transaction FSM; CS high overrides everything, so a coincident SCLK edge is dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            src        <= SRC_MEM;
            o_SPI_MISO <= 1'b0;
            o_MEM_ADDR <= '0;
            o_MEM_RD   <= 1'b0;
            o_ACTIVE   <= 1'b0;
            bit_cnt    <= 5'd0;
            shift_in   <= 7'd0;
            addr_sr    <= '0;
            sreg       <= 8'h00;
            next_byte  <= 8'h00;
            byte_ready <= 1'b0;
            first_load <= 1'b0;
            fast       <= 1'b0;
            rd_d       <= 1'b0;
            armed      <= 1'b0;
            id_idx     <= 2'd0;
        end else begin
            o_MEM_RD <= 1'b0;
            rd_d     <= o_MEM_RD;
            if (cs_s2) begin
                // armed only re-opens once CS has been seen high, so a reset with CS low stays quiet
                state      <= IDLE;
                o_SPI_MISO <= 1'b0;
                o_ACTIVE   <= 1'b0;
                bit_cnt    <= 5'd0;
                shift_in   <= 7'd0;
                addr_sr    <= '0;
                sreg       <= 8'h00;
                next_byte  <= 8'h00;
                byte_ready <= 1'b0;
                first_load <= 1'b0;
                fast       <= 1'b0;
                armed      <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (armed) begin
                            state    <= CMD;
                            o_ACTIVE <= 1'b1;
                            bit_cnt  <= 5'd0;
                            armed    <= 1'b0;
                        end
                    end
                    CMD: begin
                        if (sclk_rise) begin
                            shift_in <= {shift_in[5:0], mosi_s2};
                            bit_cnt  <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= 5'd0;
                                case ({shift_in, mosi_s2})
                                    8'h03: begin
                                        state <= ADDR;
                                        fast  <= 1'b0;
                                        src   <= SRC_MEM;
                                    end
                                    8'h0B: begin
                                        state <= ADDR;
                                        fast  <= 1'b1;
                                        src   <= SRC_MEM;
                                    end
                                    8'h9F: begin
                                        state      <= DATA;
                                        src        <= SRC_ID;
                                        id_idx     <= 2'd1;
                                        sreg       <= id_byte(2'd0);
                                        o_SPI_MISO <= JEDEC_ID[23];
                                    end
                                    8'h05: begin
                                        state      <= DATA;
                                        src        <= SRC_STATUS;
                                        sreg       <= 8'h00;
                                        o_SPI_MISO <= 1'b0;
                                    end
                                    default: begin
                                        state    <= IGNORE;
                                        o_ACTIVE <= 1'b0;
                                    end
                                endcase
                            end
                        end
                    end
                    ADDR: begin
                        if (sclk_rise) begin
                            addr_sr <= {addr_sr[ADDR_WIDTH-2:0], mosi_s2};
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd23) begin
                                bit_cnt    <= 5'd0;
                                o_MEM_ADDR <= {addr_sr[ADDR_WIDTH-2:0], mosi_s2};
                                o_MEM_RD   <= 1'b1;
                                first_load <= ~fast;
                                state      <= fast ? DUMMY : DATA;
                            end
                        end
                    end
                    DUMMY: begin
                        if (rd_d) begin
                            next_byte <= i_MEM_DATA;
                        end else if (sclk_rise) begin
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) begin
                                bit_cnt    <= 5'd0;
                                state      <= DATA;
                                sreg       <= next_byte;
                                o_SPI_MISO <= next_byte[7];
                                byte_ready <= 1'b0;
                            end
                        end
                    end
                    DATA: begin
                        if (rd_d) begin
                            if (first_load) begin
                                sreg       <= i_MEM_DATA;
                                o_SPI_MISO <= i_MEM_DATA[7];
                                first_load <= 1'b0;
                            end else begin
                                next_byte  <= i_MEM_DATA;
                                byte_ready <= 1'b1;
                            end
                        end else if (sclk_rise) begin
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= 5'd0;
                                case (src)
                                    SRC_MEM: begin
                                        o_MEM_ADDR <= o_MEM_ADDR + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                                        o_MEM_RD   <= 1'b1;
                                    end
                                    SRC_ID: begin
                                        next_byte  <= id_byte(id_idx);
                                        byte_ready <= 1'b1;
                                        id_idx     <= (id_idx == 2'd3) ? 2'd3 : id_idx + 2'd1;
                                    end
                                    default: begin
                                        next_byte  <= 8'h00;
                                        byte_ready <= 1'b1;
                                    end
                                endcase
                            end
                        end else if (sclk_fall) begin
                            // bit_cnt==0 means bit 7 is already on the pin, or a new byte is due
                            if (bit_cnt != 5'd0) begin
                                o_SPI_MISO <= sreg[6];
                                sreg       <= {sreg[6:0], 1'b0};
                            end else if (byte_ready) begin
                                sreg       <= next_byte;
                                o_SPI_MISO <= next_byte[7];
                                byte_ready <= 1'b0;
                            end
                        end
                    end
                    IGNORE: begin
                        o_SPI_MISO <= 1'b0;
                    end
                    default: begin
                        state    <= IDLE;
                        o_ACTIVE <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench for spi_flash_responder: a bit-banged SPI initiator queues expected
// MISO bytes and memory-read addresses; one monitor process pops and compares them.
module tb_spi_flash_responder;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        sclk, mosi, cs;
    logic        miso, mem_rd, active;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic [7:0]  mem [0:65535];

    int          n_pass  = 0;
    int          n_total = 0;
    logic [7:0]  exp_byte_q[$];
    logic [15:0] exp_addr_q[$];
    logic        cap_en = 1'b0;

    spi_flash_responder #(.ADDR_WIDTH(16), .JEDEC_ID(24'hEF4016)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_SPI_CLK  (sclk),
        .i_SPI_MOSI (mosi),
        .i_SPI_CS   (cs),
        .o_SPI_MISO (miso),
        .o_MEM_ADDR (mem_addr),
        .o_MEM_RD   (mem_rd),
        .i_MEM_DATA (mem_data),
        .o_ACTIVE   (active)
    );

    always #5 clk = ~clk;

    // Synchronous memory: data valid one clk after the read strobe
    always @(posedge clk) begin
        if (mem_rd === 1'b1) mem_data <= mem[mem_addr];
    end

    // Monitor: assembles MISO bits on SCLK rises and checks every memory read strobe
    initial begin
        logic       sclk_prev;
        logic       rd_prev;
        logic [7:0] rx;
        logic [7:0] eb;
        logic [15:0] ea;
        int         nbits;
        sclk_prev = 1'b0;
        rd_prev   = 1'b0;
        rx        = 8'h00;
        nbits     = 0;
        forever begin
            @(negedge clk);
            if (!cap_en) begin
                nbits = 0;
            end else if (sclk === 1'b1 && sclk_prev === 1'b0) begin
                rx = {rx[6:0], miso};
                nbits++;
                if (nbits == 8) begin
                    nbits = 0;
                    n_total++;
                    if (exp_byte_q.size() == 0) begin
                        $display("FAIL miso_byte: got %02h, required nothing (no byte expected)", rx);
                    end else begin
                        eb = exp_byte_q.pop_front();
                        if (rx === eb) n_pass++;
                        else $display("FAIL miso_byte: got %02h, required %02h", rx, eb);
                    end
                end
            end
            if (mem_rd === 1'b1) begin
                n_total++;
                if (exp_addr_q.size() == 0) begin
                    $display("FAIL mem_rd_addr: got read of %04h, required no read", mem_addr);
                end else begin
                    ea = exp_addr_q.pop_front();
                    if (mem_addr === ea && rd_prev !== 1'b1) n_pass++;
                    else $display("FAIL mem_rd_addr: got %04h (prev strobe %b), required %04h single-cycle",
                                  mem_addr, rd_prev, ea);
                end
            end
            sclk_prev = sclk;
            rd_prev   = mem_rd;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    endtask

    task automatic spi_bit(input logic b);
        mosi = b;
        tick(HALF);
        sclk = 1'b1;
        tick(HALF);
        sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) spi_bit(v[i]);
    endtask

    task automatic spi_addr(input logic [23:0] a);
        for (int i = 23; i >= 0; i--) spi_bit(a[i]);
    endtask

    task automatic cs_low();
        cs = 1'b0;
        tick(HALF);
    endtask

    task automatic cs_high();
        tick(HALF);
        cs = 1'b1;
        tick(3 * HALF);
    endtask

    // Clock out n bytes while capturing, after the expected values are queued
    task automatic read_bytes(input int n);
        cap_en = 1'b1;
        for (int i = 0; i < n; i++) spi_byte(8'h00);
        cap_en = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        reset = 1'b1;
        sclk  = 1'b0;
        mosi  = 1'b0;
        cs    = 1'b1;
        tick(5);
        reset = 1'b0;
        tick(5);
        chk("reset_miso",   {31'd0, miso},     32'd0);
        chk("reset_rd",     {31'd0, mem_rd},   32'd0);
        chk("reset_addr",   {16'd0, mem_addr}, 32'd0);
        chk("reset_active", {31'd0, active},   32'd0);

        // READ at 0x001234, two bytes
        mem[16'h1234] = 8'hA5;
        mem[16'h1235] = 8'h3C;
        exp_addr_q.push_back(16'h1234);
        exp_addr_q.push_back(16'h1235);
        exp_addr_q.push_back(16'h1236);
        exp_byte_q.push_back(8'hA5);
        exp_byte_q.push_back(8'h3C);
        cs_low();
        spi_byte(8'h03);
        chk("active_cmd", {31'd0, active}, 32'd1);
        spi_addr(24'h001234);
        read_bytes(2);
        cs_high();

        // READ at 0xFFFFFF wraps through 0xFFFF to 0x0000
        mem[16'hFFFF] = 8'h11;
        mem[16'h0000] = 8'h22;
        exp_addr_q.push_back(16'hFFFF);
        exp_addr_q.push_back(16'h0000);
        exp_addr_q.push_back(16'h0001);
        exp_byte_q.push_back(8'h11);
        exp_byte_q.push_back(8'h22);
        cs_low();
        spi_byte(8'h03);
        spi_addr(24'hFFFFFF);
        read_bytes(2);
        cs_high();

        // FAST READ: MISO must be 0 through the dummy byte
        mem[16'h0010] = 8'h5A;
        exp_addr_q.push_back(16'h0010);
        exp_addr_q.push_back(16'h0011);
        exp_byte_q.push_back(8'h00);
        exp_byte_q.push_back(8'h5A);
        cs_low();
        spi_byte(8'h0B);
        spi_addr(24'h000010);
        cap_en = 1'b1;
        spi_byte(8'hFF);
        spi_byte(8'h00);
        cap_en = 1'b0;
        cs_high();

        // JEDEC ID, no memory reads expected
        exp_byte_q.push_back(8'hEF);
        exp_byte_q.push_back(8'h40);
        exp_byte_q.push_back(8'h16);
        exp_byte_q.push_back(8'h00);
        cs_low();
        spi_byte(8'h9F);
        read_bytes(4);
        cs_high();

        // Unknown command is ignored, then a fresh READ STATUS
        exp_byte_q.push_back(8'h00);
        exp_byte_q.push_back(8'h00);
        cs_low();
        spi_byte(8'h02);
        chk("active_ignore", {31'd0, active}, 32'd0);
        cap_en = 1'b1;
        spi_byte(8'hAA);
        spi_byte(8'h55);
        cap_en = 1'b0;
        cs_high();
        exp_byte_q.push_back(8'h00);
        cs_low();
        spi_byte(8'h05);
        read_bytes(1);
        cs_high();

        // CS aborted after 12 address bits, then a clean READ at 0
        cs_low();
        spi_byte(8'h03);
        for (int i = 0; i < 12; i++) spi_bit(i[0]);
        cs_high();
        mem[16'h0000] = 8'h77;
        exp_addr_q.push_back(16'h0000);
        exp_addr_q.push_back(16'h0001);
        exp_byte_q.push_back(8'h77);
        cs_low();
        spi_byte(8'h03);
        spi_addr(24'h000000);
        read_bytes(1);
        cs_high();

        // Reset during the DATA phase while MISO is driving a 1
        mem[16'h0020] = 8'hFF;
        exp_addr_q.push_back(16'h0020);
        cs_low();
        spi_byte(8'h03);
        spi_addr(24'h000020);
        spi_bit(1'b0);
        spi_bit(1'b0);
        spi_bit(1'b0);
        chk("miso_before_reset", {31'd0, miso}, 32'd1);
        reset = 1'b1;
        tick(1);
        chk("midreset_miso",   {31'd0, miso},     32'd0);
        chk("midreset_rd",     {31'd0, mem_rd},   32'd0);
        chk("midreset_addr",   {16'd0, mem_addr}, 32'd0);
        chk("midreset_active", {31'd0, active},   32'd0);
        reset = 1'b0;
        tick(2);
        // CS never went high after reset: a command must not be recognized
        spi_byte(8'h9F);
        chk("rearm_active", {31'd0, active}, 32'd0);
        chk("rearm_miso",   {31'd0, miso},   32'd0);
        cs_high();
        exp_byte_q.push_back(8'hEF);
        cs_low();
        spi_byte(8'h9F);
        read_bytes(1);
        cs_high();

        tick(20);
        chk("byte_queue_drained", exp_byte_q.size(), 32'd0);
        chk("addr_queue_drained", exp_addr_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
